// File: rtl/pipeline_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states,
// the hard-wired zero register and bit positions of the stage-enable bundle.
package pipeline_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } hz_state_t;

  // $zero never creates a dependency, whatever the load targets.
  localparam int REG_ZERO = 0;

  // Bit positions inside the stage write-enable bundle.
  localparam int EN_PC     = 0;
  localparam int EN_IF_ID  = 1;
  localparam int EN_ID_EX  = 2;
  localparam int EN_EX_MEM = 3;
  localparam int EN_MEM_WB = 4;
  localparam int NUM_EN    = 5;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter
  import pipeline_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Clear wins over increment; once all-ones the value is held.
  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage core: load-use bubbles, EX-resolved
// branch flushes, whole-pipe freeze on data-memory wait with a watchdog that
// traps to a sticky error state, plus saturating stall/flush counters.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [REG_AW-1:0] ID_RS,
  input  logic [REG_AW-1:0] ID_RT,
  input  logic              ID_USES_RT,
  input  logic [REG_AW-1:0] EX_RT,
  input  logic              EX_MEM_READ,
  input  logic              EX_BR_TAKEN,
  input  logic              MEM_REQ,
  input  logic              MEM_READY,
  output logic              PC_WRITE,
  output logic              PC_SRC_BR,
  output logic              IF_ID_WRITE,
  output logic              IF_ID_FLUSH,
  output logic              ID_EX_WRITE,
  output logic              ID_EX_FLUSH,
  output logic              EX_MEM_WRITE,
  output logic              MEM_WB_WRITE,
  output logic              MEM_ERR,
  output logic [CNT_W-1:0]  STALL_CNT,
  output logic [CNT_W-1:0]  FLUSH_CNT
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  hz_state_t         state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic              freeze;
  logic              load_use;
  logic [NUM_EN-1:0] wr_en;
  logic              pc_src_br;
  logic              if_id_flush;
  logic              id_ex_flush;

  assign freeze   = MEM_REQ && !MEM_READY;
  assign load_use = EX_MEM_READ
                    && (EX_RT != REG_AW'(REG_ZERO))
                    && ((EX_RT == ID_RS) || (ID_USES_RT && (EX_RT == ID_RT)));

  // State and watchdog registers; reset returns to RUN with a clean count.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Next state: wait_cnt counts every consecutive not-ready cycle of the
  // access, the one that opened the wait included, so ERROR is reached right
  // after MEM_TIMEOUT such cycles.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      ST_RUN: begin
        wait_d = '0;
        if (freeze) begin
          state_d = ST_MEM_WAIT;
          wait_d  = WAIT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (MEM_READY) begin
          state_d = ST_RUN;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + 1'b1;
          if (wait_d >= WAIT_W'(MEM_TIMEOUT)) begin
            state_d = ST_ERROR;
          end
        end
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d = ST_RUN;
        wait_d  = '0;
      end
    endcase
  end

  // Control decode, highest priority first: reset, error, freeze, branch,
  // load-use, normal flow. A released MEM_WAIT decodes exactly like RUN.
  always_comb begin
    wr_en       = '1;
    pc_src_br   = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (RST) begin
      wr_en       = '0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (state_q == ST_ERROR) begin
      wr_en = '0;
    end else if (freeze) begin
      wr_en = '0;
    end else if (EX_BR_TAKEN) begin
      // Squashes the wrong-path instructions in IF and ID, including any
      // dependent of a coincident load.
      pc_src_br   = 1'b1;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      // Hold PC and IF/ID for one cycle and inject a bubble into EX; the
      // load moves on to MEM, so the hazard clears by itself next cycle.
      wr_en[EN_PC]    = 1'b0;
      wr_en[EN_IF_ID] = 1'b0;
      id_ex_flush     = 1'b1;
    end
  end

  assign PC_WRITE     = wr_en[EN_PC];
  assign IF_ID_WRITE  = wr_en[EN_IF_ID];
  assign ID_EX_WRITE  = wr_en[EN_ID_EX];
  assign EX_MEM_WRITE = wr_en[EN_EX_MEM];
  assign MEM_WB_WRITE = wr_en[EN_MEM_WB];
  assign PC_SRC_BR    = pc_src_br;
  assign IF_ID_FLUSH  = if_id_flush;
  assign ID_EX_FLUSH  = id_ex_flush;
  assign MEM_ERR      = (state_q == ST_ERROR) && !RST;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (CLK),
    .clr   (RST),
    .inc   (!wr_en[EN_PC]),
    .count (STALL_CNT)
  );

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_flush_cnt (
    .clk   (CLK),
    .clr   (RST),
    .inc   (if_id_flush),
    .count (FLUSH_CNT)
  );

endmodule
